// File: rtl/mem_pkg.sv
// Shared definitions for the memory pipeline stage.
// FSM states, load/store size encodings and sideband width.
package mem_pkg;

  localparam int SIDE_W = 72;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte/halfword lane handling for loads and stores.
// Pure combinational; unknown funct3 falls back to word access.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wmask
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ldata = i_rdata;
    case (i_funct3)
      F3_B:  o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_H:  o_ldata = {{16{w_half[15]}}, w_half};
      F3_BU: o_ldata = {24'd0, w_byte};
      F3_HU: o_ldata = {16'd0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

  always_comb begin
    o_wmask = 4'b1111;
    o_wdata = i_sdata;
    case (i_funct3)
      F3_B: begin
        o_wmask = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_sdata[7:0]}};
      end
      F3_H: begin
        o_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_sdata[15:0]}};
      end
      default: begin
        o_wmask = 4'b1111;
        o_wdata = i_sdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: holds one instruction, runs one data-bus
// transaction for loads/stores, and hands results to WB.
module mem_stage
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              mem_ready,
  input  logic [31:0]       pc_ex,
  input  logic [31:0]       inst_ex,
  input  logic [31:0]       alu_res_ex,
  input  logic [31:0]       store_data_ex,
  input  logic              load_en_ex,
  input  logic              store_en_ex,
  input  logic [2:0]        funct3_ex,
  input  logic [SIDE_W-1:0] side_ex,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wen,
  output logic [31:0]       dmem_req_addr,
  output logic [31:0]       dmem_req_wdata,
  output logic [3:0]        dmem_req_wmask,
  input  logic              dmem_resp_valid,
  input  logic [31:0]       dmem_resp_rdata,
  output logic              mem_valid,
  input  logic              wb_ready,
  output logic [31:0]       pc_mem,
  output logic [31:0]       inst_mem,
  output logic [31:0]       load_data_mem,
  output logic [31:0]       alu_res_mem,
  output logic [SIDE_W-1:0] side_mem
);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic              r_valid;
  logic [31:0]       r_pc;
  logic [31:0]       r_inst;
  logic [31:0]       r_alu;
  logic [31:0]       r_sdata;
  logic [31:0]       r_ldata;
  logic              r_load;
  logic              r_store;
  logic [2:0]        r_f3;
  logic [SIDE_W-1:0] r_side;

  logic        w_mem_op;
  logic        w_ready_go;
  logic        w_accept;
  logic        w_new_mem;
  logic [31:0] w_ldata;
  logic [31:0] w_wdata;
  logic [3:0]  w_wmask;

  assign w_mem_op   = r_load | r_store;
  assign w_ready_go = r_valid &
                      ((r_state == S_DONE) | ~w_mem_op);
  assign mem_ready  = ~r_valid | (w_ready_go & wb_ready);
  assign mem_valid  = w_ready_go;
  assign w_accept   = ex_valid & mem_ready;
  assign w_new_mem  = w_accept & (load_en_ex | store_en_ex);

  mem_align u_align (
    .i_funct3  (r_f3),
    .i_addr_lo (r_alu[1:0]),
    .i_rdata   (dmem_resp_rdata),
    .i_sdata   (r_sdata),
    .o_ldata   (w_ldata),
    .o_wdata   (w_wdata),
    .o_wmask   (w_wmask)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // DONE hands off like IDLE: a new load/store may enter the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE:
        if (mem_ready) w_next = w_new_mem ? S_REQ : S_IDLE;
      S_REQ:
        if (dmem_req_ready) w_next = S_WAIT;
      S_WAIT:
        if (dmem_resp_valid) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_alu   <= '0;
      r_sdata <= '0;
      r_ldata <= '0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_f3    <= '0;
      r_side  <= '0;
    end else begin
      if (mem_ready) r_valid <= ex_valid;
      if (w_accept) begin
        r_pc    <= pc_ex;
        r_inst  <= inst_ex;
        r_alu   <= alu_res_ex;
        r_sdata <= store_data_ex;
        r_load  <= load_en_ex;
        r_store <= store_en_ex & ~load_en_ex;
        r_f3    <= funct3_ex;
        r_side  <= side_ex;
        r_ldata <= '0;
      end else if (r_state == S_WAIT && dmem_resp_valid) begin
        r_ldata <= r_load ? w_ldata : '0;
      end
    end
  end

  assign dmem_req_valid = (r_state == S_REQ);
  assign dmem_req_wen   = r_store;
  assign dmem_req_addr  = {r_alu[31:2], 2'b00};
  assign dmem_req_wdata = r_store ? w_wdata : '0;
  assign dmem_req_wmask = r_store ? w_wmask : '0;

  assign pc_mem        = r_pc;
  assign inst_mem      = r_inst;
  assign alu_res_mem   = r_alu;
  assign load_data_mem = r_ldata;
  assign side_mem      = r_side;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads,
// stores, back-pressure on both sides and reset abandonment.
module tb_mem_stage;
  import mem_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              ex_valid;
  logic              mem_ready;
  logic [31:0]       pc_ex;
  logic [31:0]       inst_ex;
  logic [31:0]       alu_res_ex;
  logic [31:0]       store_data_ex;
  logic              load_en_ex;
  logic              store_en_ex;
  logic [2:0]        funct3_ex;
  logic [SIDE_W-1:0] side_ex;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_wen;
  logic [31:0]       dmem_req_addr;
  logic [31:0]       dmem_req_wdata;
  logic [3:0]        dmem_req_wmask;
  logic              dmem_resp_valid;
  logic [31:0]       dmem_resp_rdata;
  logic              mem_valid;
  logic              wb_ready;
  logic [31:0]       pc_mem;
  logic [31:0]       inst_mem;
  logic [31:0]       load_data_mem;
  logic [31:0]       alu_res_mem;
  logic [SIDE_W-1:0] side_mem;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ex_valid        (ex_valid),
    .mem_ready       (mem_ready),
    .pc_ex           (pc_ex),
    .inst_ex         (inst_ex),
    .alu_res_ex      (alu_res_ex),
    .store_data_ex   (store_data_ex),
    .load_en_ex      (load_en_ex),
    .store_en_ex     (store_en_ex),
    .funct3_ex       (funct3_ex),
    .side_ex         (side_ex),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_wen    (dmem_req_wen),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wmask  (dmem_req_wmask),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata),
    .mem_valid       (mem_valid),
    .wb_ready        (wb_ready),
    .pc_mem          (pc_mem),
    .inst_mem        (inst_mem),
    .load_data_mem   (load_data_mem),
    .alu_res_mem     (alu_res_mem),
    .side_mem        (side_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Memory op with bus ready and response granted on first cycle.
  task automatic xfer(input string tag,
                      input logic ld, input logic st,
                      input logic [2:0] f3,
                      input logic [31:0] addr,
                      input logic [31:0] sdata,
                      input logic [31:0] rdata,
                      input logic [31:0] exp_ld,
                      input logic [3:0] exp_mask,
                      input logic [31:0] exp_wdata);
    logic [31:0] a;
    a = addr;
    ex_valid = 1'b1;
    load_en_ex = ld;
    store_en_ex = st;
    funct3_ex = f3;
    alu_res_ex = addr;
    store_data_ex = sdata;
    dmem_req_ready = 1'b1;
    dmem_resp_valid = 1'b0;
    step();
    ex_valid = 1'b0;
    load_en_ex = 1'b0;
    store_en_ex = 1'b0;
    chk({tag, "_reqv"}, 72'(dmem_req_valid), 72'd1);
    chk({tag, "_addr"}, 72'(dmem_req_addr), 72'({a[31:2], 2'b00}));
    chk({tag, "_wen"}, 72'(dmem_req_wen), 72'(st & ~ld));
    chk({tag, "_wmask"}, 72'(dmem_req_wmask), 72'(exp_mask));
    chk({tag, "_wdata"}, 72'(dmem_req_wdata), 72'(exp_wdata));
    chk({tag, "_rdy_req"}, 72'(mem_ready), 72'd0);
    step();
    chk({tag, "_wait_reqv"}, 72'(dmem_req_valid), 72'd0);
    chk({tag, "_wait_mv"}, 72'(mem_valid), 72'd0);
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = rdata;
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'hDEAD_DEAD;
    chk({tag, "_mv"}, 72'(mem_valid), 72'd1);
    chk({tag, "_ldata"}, 72'(load_data_mem), 72'(exp_ld));
    step();
    chk({tag, "_mv_off"}, 72'(mem_valid), 72'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    ex_valid = 1'b0;
    pc_ex = '0;
    inst_ex = '0;
    alu_res_ex = '0;
    store_data_ex = '0;
    load_en_ex = 1'b0;
    store_en_ex = 1'b0;
    funct3_ex = '0;
    side_ex = '0;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = '0;
    wb_ready = 1'b1;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_mv", 72'(mem_valid), 72'd0);
    chk("rst_reqv", 72'(dmem_req_valid), 72'd0);
    chk("rst_pc", 72'(pc_mem), 72'd0);
    chk("rst_ld", 72'(load_data_mem), 72'd0);
    chk("rst_wmask", 72'(dmem_req_wmask), 72'd0);
    chk("rst_side", side_mem, 72'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_rdy", 72'(mem_ready), 72'd1);

    // ALU op: one-cycle pass, no bus traffic
    ex_valid = 1'b1;
    pc_ex = 32'h8000_0000;
    inst_ex = 32'h0000_0013;
    alu_res_ex = 32'h1234_5678;
    side_ex = 72'hA5_0123_4567_89AB_CDEF;
    step();
    ex_valid = 1'b0;
    chk("alu_mv", 72'(mem_valid), 72'd1);
    chk("alu_res", 72'(alu_res_mem), 72'h1234_5678);
    chk("alu_pc", 72'(pc_mem), 72'h8000_0000);
    chk("alu_inst", 72'(inst_mem), 72'h13);
    chk("alu_side", side_mem, 72'hA5_0123_4567_89AB_CDEF);
    chk("alu_reqv", 72'(dmem_req_valid), 72'd0);
    step();
    chk("alu_mv_off", 72'(mem_valid), 72'd0);
    chk("alu_reqv2", 72'(dmem_req_valid), 72'd0);

    xfer("lb", 1'b1, 1'b0, F3_B, 32'h0000_1003, 32'h0,
         32'h80FF_0000, 32'hFFFF_FF80, 4'b0000, 32'h0);
    xfer("lh", 1'b1, 1'b0, F3_H, 32'h0000_0042, 32'h0,
         32'h8001_7FFF, 32'hFFFF_8001, 4'b0000, 32'h0);
    xfer("lbu", 1'b1, 1'b0, F3_BU, 32'h0000_0041, 32'h0,
         32'h1122_F344, 32'h0000_00F3, 4'b0000, 32'h0);
    xfer("sb", 1'b0, 1'b1, F3_B, 32'h0000_3001, 32'h0000_0077,
         32'hFFFF_FFFF, 32'h0, 4'b0010, 32'h7777_7777);
    xfer("sw", 1'b0, 1'b1, F3_W, 32'h0000_4007, 32'hCAFE_F00D,
         32'hFFFF_FFFF, 32'h0, 4'b1111, 32'hCAFE_F00D);
    xfer("ldst", 1'b1, 1'b1, F3_W, 32'h0000_0020, 32'h5555_5555,
         32'h0BAD_BEEF, 32'h0BAD_BEEF, 4'b0000, 32'h0);
    xfer("lund", 1'b1, 1'b0, 3'b111, 32'h0000_0051, 32'h0,
         32'h8765_4321, 32'h8765_4321, 4'b0000, 32'h0);

    // SH with request back-pressure and stray responses during REQ
    ex_valid = 1'b1;
    store_en_ex = 1'b1;
    funct3_ex = F3_H;
    alu_res_ex = 32'h0000_2002;
    store_data_ex = 32'h1234_ABCD;
    dmem_req_ready = 1'b0;
    step();
    ex_valid = 1'b0;
    store_en_ex = 1'b0;
    alu_res_ex = 32'hFFFF_FFFF;
    store_data_ex = 32'h0;
    dmem_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("sh_reqv", 72'(dmem_req_valid), 72'd1);
      chk("sh_addr", 72'(dmem_req_addr), 72'h2000);
      chk("sh_wmask", 72'(dmem_req_wmask), 72'hC);
      chk("sh_wdata", 72'(dmem_req_wdata), 72'hABCD_ABCD);
      chk("sh_wen", 72'(dmem_req_wen), 72'd1);
      chk("sh_rdy", 72'(mem_ready), 72'd0);
      step();
    end
    dmem_resp_valid = 1'b0;
    dmem_req_ready = 1'b1;
    chk("sh_reqv_last", 72'(dmem_req_valid), 72'd1);
    step();
    chk("sh_wait_reqv", 72'(dmem_req_valid), 72'd0);
    chk("sh_wait_rdy", 72'(mem_ready), 72'd0);
    step();
    chk("sh_wait_hold", 72'(mem_valid), 72'd0);
    dmem_resp_valid = 1'b1;
    step();
    dmem_resp_valid = 1'b0;
    chk("sh_done_mv", 72'(mem_valid), 72'd1);
    chk("sh_done_ld", 72'(load_data_mem), 72'd0);
    chk("sh_done_rdy", 72'(mem_ready), 72'd1);
    step();
    chk("sh_idle_mv", 72'(mem_valid), 72'd0);

    // LHU held by WB back-pressure, next load waiting in EX
    ex_valid = 1'b1;
    load_en_ex = 1'b1;
    funct3_ex = F3_HU;
    alu_res_ex = 32'h0000_0010;
    inst_ex = 32'h0101_5083;
    step();
    ex_valid = 1'b0;
    load_en_ex = 1'b0;
    step();
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hBEEF_8001;
    wb_ready = 1'b0;
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'h1111_1111;
    ex_valid = 1'b1;
    load_en_ex = 1'b1;
    funct3_ex = F3_W;
    alu_res_ex = 32'h0000_0024;
    inst_ex = 32'h0240_2103;
    for (int i = 0; i < 3; i++) begin
      chk("lhu_mv_hold", 72'(mem_valid), 72'd1);
      chk("lhu_ld_hold", 72'(load_data_mem), 72'h8001);
      chk("lhu_inst_hold", 72'(inst_mem), 72'h0101_5083);
      chk("lhu_rdy_hold", 72'(mem_ready), 72'd0);
      chk("lhu_reqv_hold", 72'(dmem_req_valid), 72'd0);
      step();
    end
    wb_ready = 1'b1;
    #1;
    chk("lhu_rdy_rise", 72'(mem_ready), 72'd1);
    step();
    ex_valid = 1'b0;
    load_en_ex = 1'b0;
    chk("b2b_reqv", 72'(dmem_req_valid), 72'd1);
    chk("b2b_addr", 72'(dmem_req_addr), 72'h24);
    chk("b2b_mv", 72'(mem_valid), 72'd0);
    chk("b2b_inst", 72'(inst_mem), 72'h0240_2103);
    step();
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hCAFE_BABE;
    step();
    dmem_resp_valid = 1'b0;
    chk("b2b_ld", 72'(load_data_mem), 72'hCAFE_BABE);
    chk("b2b_done_mv", 72'(mem_valid), 72'd1);
    step();

    // Reset while a load waits for its response
    ex_valid = 1'b1;
    load_en_ex = 1'b1;
    funct3_ex = F3_W;
    alu_res_ex = 32'h0000_0080;
    dmem_req_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    load_en_ex = 1'b0;
    step();
    chk("rw_wait_reqv", 72'(dmem_req_valid), 72'd0);
    chk("rw_wait_rdy", 72'(mem_ready), 72'd0);
    reset_n = 1'b0;
    #2;
    chk("rw_rst_mv", 72'(mem_valid), 72'd0);
    chk("rw_rst_rdy", 72'(mem_ready), 72'd1);
    chk("rw_rst_alu", 72'(alu_res_mem), 72'd0);
    reset_n = 1'b1;
    #1;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h7777_7777;
    step();
    chk("rw_stray_mv", 72'(mem_valid), 72'd0);
    chk("rw_stray_rdy", 72'(mem_ready), 72'd1);
    chk("rw_stray_reqv", 72'(dmem_req_valid), 72'd0);
    step();
    dmem_resp_valid = 1'b0;
    chk("rw_stray_mv2", 72'(mem_valid), 72'd0);
    chk("rw_stray_ld", 72'(load_data_mem), 72'd0);

    // Fresh ALU op after the abandoned load still passes in one cycle
    ex_valid = 1'b1;
    alu_res_ex = 32'h0000_0ABC;
    step();
    ex_valid = 1'b0;
    chk("post_mv", 72'(mem_valid), 72'd1);
    chk("post_alu", 72'(alu_res_mem), 72'hABC);
    chk("post_reqv", 72'(dmem_req_valid), 72'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have no parameters; all data/address widths fixed at 32 bits, sideband 72 bits.
REQ-002 SHALL have ports: clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ex_valid in 1 EX holds valid instr; mem_ready out 1 stage can accept.
REQ-005 SHALL have ports: pc_ex, inst_ex, alu_res_ex (result/address), store_data_ex  in  32 each.
REQ-006 SHALL have ports: load_en_ex in 1; store_en_ex in 1; funct3_ex in 3 access size/sign.
REQ-007 SHALL have ports: side_ex in 72 opaque bundle {csr_rdata, sel_rf_wdata, ecall, mret, rf_wen, csr_wen, csr_wdata, ebreak}, passed through unchanged.
REQ-008 SHALL have ports: dmem_req_valid out 1; dmem_req_ready in 1; dmem_req_wen out 1; dmem_req_addr out 32; dmem_req_wdata out 32; dmem_req_wmask out 4.
REQ-009 SHALL have ports: dmem_resp_valid in 1; dmem_resp_rdata in 32.
REQ-010 SHALL have ports: mem_valid out 1; wb_ready in 1; pc_mem, inst_mem, load_data_mem, alu_res_mem out 32; side_mem out 72.

Function
REQ-011 SHALL capture all EX inputs into stage registers at a rising edge where ex_valid && mem_ready; valid <= ex_valid whenever mem_ready.
REQ-012 SHALL drive mem_ready = !valid || (ready_go && wb_ready) combinationally, with ready_go = valid && (state==DONE || !(load||store)).
REQ-013 SHALL drive mem_valid = valid && ready_go; non-memory instructions therefore pass in one cycle with no bus activity.
REQ-014 SHALL implement FSM IDLE -> REQ (on accept of load/store) -> WAIT (on dmem_req_valid && dmem_req_ready) -> DONE (on dmem_resp_valid) -> IDLE or REQ (on wb_ready; REQ if the simultaneously accepted instr is load/store).
REQ-015 SHALL assert dmem_req_valid only in REQ and hold addr/wdata/wmask/wen stable until dmem_req_ready.
REQ-016 SHALL ignore dmem_resp_valid in any state other than WAIT; stores also wait for a response before DONE.
REQ-017 SHALL latch load data in the WAIT->DONE cycle: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane addr[1:0], halfword lane addr[1]; sign/zero-extend to 32; stores drive load_data_mem = 0.
REQ-018 SHALL form stores: SB wmask 0001<<addr[1:0], wdata byte replicated x4; SH wmask 0011<<(2*addr[1]), halfword replicated x2; SW 1111; dmem_req_addr = alu_res with addr[1:0] zeroed.
REQ-019 SHALL ignore misalignment beyond REQ-017/018 lane selection (no trap); undefined funct3 SHALL behave as LW/SW.
REQ-020 SHALL give minimum load/store latency of 3 cycles accept->mem_valid (REQ, WAIT, DONE) with ready/resp each granted first cycle.
REQ-021 SHALL hold mem_valid and all *_mem outputs stable while mem_valid && !wb_ready.
REQ-022 SHALL, when load_en_ex and store_en_ex are both set, treat the instr as a load.

Reset
REQ-023 SHALL on reset_n low, immediately and asynchronously: valid=0, state=IDLE, dmem_req_valid=0, mem_valid=0, all *_mem and dmem_req_* data outputs=0.
REQ-024 SHALL abandon any in-flight transaction on reset; a late dmem_resp_valid after release SHALL be ignored (IDLE).
REQ-025 SHALL after reset release present mem_ready=1 in the first cycle.

Structure
REQ-026 SHALL place FSM state enum, funct3 load/store constants and SIDE_W=72 in shared package mem_pkg.
REQ-027 SHALL put lane extraction/extension and store mask/data replication in one combinational sub-module mem_align.

Verification
REQ-028 ALU op pc=0x80000000, wb_ready=1 -> mem_valid next cycle, alu_res_mem passes, no dmem_req_valid.
REQ-029 LB addr 0x1003, rdata 0x80FF_0000, req_ready/resp immediate -> load_data_mem=0xFFFFFF80 three cycles after accept.
REQ-030 SH addr 0x2002, store_data 0x1234ABCD, req_ready low 4 cycles -> addr 0x2000, wmask 1100, wdata 0xABCDABCD stable throughout; mem_ready=0 until DONE.
REQ-031 LHU addr 0x10, resp arrives, wb_ready low 3 cycles -> mem_valid held, load_data_mem=zero-extended half stable; back-to-back load accepted the cycle wb_ready rises.
REQ-032 Load in WAIT, reset_n pulsed, then stray dmem_resp_valid -> mem_valid stays 0, state IDLE, mem_ready=1.
